// File: rtl/ibex_lsu_pipelined_if.sv
// rtl/ibex_lsu_pipelined_if.sv - core request, data bus and response signals of the pipelined LSU
interface ibex_lsu_pipelined_if #(
  parameter int DW = 32
);
  logic            req_valid_i;
  logic            req_ready_o;
  logic            req_we_i;
  logic [1:0]      req_type_i;
  logic            req_sign_ext_i;
  logic [31:0]     req_addr_i;
  logic [DW-1:0]   req_wdata_i;
  logic            data_req_o;
  logic            data_gnt_i;
  logic [31:0]     data_addr_o;
  logic            data_we_o;
  logic [DW/8-1:0] data_be_o;
  logic [DW-1:0]   data_wdata_o;
  logic            data_rvalid_i;
  logic            data_err_i;
  logic [DW-1:0]   data_rdata_i;
  logic            rsp_valid_o;
  logic            rsp_we_o;
  logic            rsp_err_o;
  logic [31:0]     rsp_addr_o;
  logic [DW-1:0]   rsp_rdata_o;
  logic            busy_o;

  // LSU side
  modport slave (
    input  req_valid_i, req_we_i, req_type_i, req_sign_ext_i, req_addr_i, req_wdata_i,
    input  data_gnt_i, data_rvalid_i, data_err_i, data_rdata_i,
    output req_ready_o, data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
    output rsp_valid_o, rsp_we_o, rsp_err_o, rsp_addr_o, rsp_rdata_o, busy_o
  );

  // core + memory side
  modport master (
    output req_valid_i, req_we_i, req_type_i, req_sign_ext_i, req_addr_i, req_wdata_i,
    output data_gnt_i, data_rvalid_i, data_err_i, data_rdata_i,
    input  req_ready_o, data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
    input  rsp_valid_o, rsp_we_o, rsp_err_o, rsp_addr_o, rsp_rdata_o, busy_o
  );
endinterface

// File: rtl/ibex_lsu_pipelined.sv
// rtl/ibex_lsu_pipelined.sv - load/store unit splitting misaligned accesses into pipelined bus beats
module ibex_lsu_pipelined #(
  parameter int DW              = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input logic                 clk_i,
  input logic                 rst_i,
  ibex_lsu_pipelined_if.slave lsu
);
  localparam int NB = DW / 8;
  localparam int OW = $clog2(NB);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {IDLE, ISSUE_LO, ISSUE_HI} state_e;

  function automatic logic [3:0] size_bytes(input logic [1:0] t);
    case (t)
      2'b00:   return 4'd4;
      2'b01:   return 4'd2;
      2'b10:   return 4'd1;
      default: return (DW == 64) ? 4'd8 : 4'd1;
    endcase
  endfunction

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  state_e        state_q, state_d;
  logic          we_q, sign_q, split_q;
  logic [1:0]    type_q;
  logic [31:0]   addr_q;
  logic [DW-1:0] wdata_q;

  logic          tr_lo_q   [MAX_OUTSTANDING];
  logic          tr_last_q [MAX_OUTSTANDING];
  logic          tr_we_q   [MAX_OUTSTANDING];
  logic          tr_sign_q [MAX_OUTSTANDING];
  logic [1:0]    tr_type_q [MAX_OUTSTANDING];
  logic [31:0]   tr_addr_q [MAX_OUTSTANDING];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [DW-1:0] hold_q;
  logic          err_hold_q;

  logic          accept, split_in, issuing, tr_full, push, pop, rsp_fire;
  logic [OW-1:0] off_q;
  logic [3:0]    sz_q;
  logic [31:0]   aligned_addr;
  logic [2*NB-1:0] be_base, be_span;
  logic [OW+2:0] wsh;
  logic [DW-1:0] wdata_rot;

  assign accept   = (state_q == IDLE) & lsu.req_valid_i;
  assign split_in = (5'(lsu.req_addr_i[OW-1:0]) + 5'(size_bytes(lsu.req_type_i))) > 5'(NB);

  assign off_q        = addr_q[OW-1:0];
  assign sz_q         = size_bytes(type_q);
  assign aligned_addr = {addr_q[31:OW], {OW{1'b0}}};
  // Byte mask spanning both beats; low half is the LO beat, high half the HI beat.
  assign be_base      = (2*NB)'((32'd1 << sz_q) - 32'd1);
  assign be_span      = be_base << off_q;
  assign wsh          = {off_q, 3'b000};
  assign wdata_rot    = (wdata_q << wsh) | (wdata_q >> (DW - int'(wsh)));

  assign issuing = (state_q != IDLE);
  assign tr_full = (count_q == CW'(MAX_OUTSTANDING));
  assign push    = lsu.data_req_o & lsu.data_gnt_i;
  assign pop     = lsu.data_rvalid_i & (count_q != '0);

  assign lsu.req_ready_o  = (state_q == IDLE) & ~rst_i;
  assign lsu.data_req_o   = issuing & ~tr_full;
  assign lsu.data_we_o    = issuing & we_q;
  assign lsu.data_addr_o  = (state_q == ISSUE_HI) ? aligned_addr + 32'(NB) :
                            (state_q == ISSUE_LO) ? aligned_addr : 32'd0;
  assign lsu.data_be_o    = (state_q == ISSUE_HI) ? be_span[2*NB-1:NB] :
                            (state_q == ISSUE_LO) ? be_span[NB-1:0] : '0;
  assign lsu.data_wdata_o = issuing ? wdata_rot : '0;
  assign lsu.busy_o       = issuing | (count_q != '0);

  // Issue FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Issue FSM next state: one LO beat, plus a HI beat for split accesses
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (lsu.req_valid_i) state_d = ISSUE_LO;
      ISSUE_LO: if (push) state_d = split_q ? ISSUE_HI : IDLE;
      ISSUE_HI: if (push) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Capture the accepted request for the duration of its issue
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_q <= 1'b0; sign_q <= 1'b0; split_q <= 1'b0;
      type_q <= 2'b00; addr_q <= 32'd0; wdata_q <= '0;
    end else if (accept) begin
      we_q    <= lsu.req_we_i;
      sign_q  <= lsu.req_sign_ext_i;
      split_q <= split_in;
      type_q  <= lsu.req_type_i;
      addr_q  <= lsu.req_addr_i;
      wdata_q <= lsu.req_wdata_i;
    end
  end

  logic            h_lo, h_last, h_we, h_sign;
  logic [1:0]      h_type;
  logic [31:0]     h_addr;
  logic [3:0]      h_sz;
  logic [OW-1:0]   h_off;
  logic [2*DW-1:0] rd_dbl;
  logic [DW-1:0]   rd_shift, load_res;
  logic            ext;

  assign h_lo     = tr_lo_q[rd_ptr_q];
  assign h_last   = tr_last_q[rd_ptr_q];
  assign h_we     = tr_we_q[rd_ptr_q];
  assign h_sign   = tr_sign_q[rd_ptr_q];
  assign h_type   = tr_type_q[rd_ptr_q];
  assign h_addr   = tr_addr_q[rd_ptr_q];
  assign h_sz     = size_bytes(h_type);
  assign h_off    = h_addr[OW-1:0];
  assign rsp_fire = pop & h_last;

  // Merge the held LO beat with the returning beat, align and extend
  always_comb begin
    rd_dbl   = h_lo ? {{DW{1'b0}}, lsu.data_rdata_i} : {lsu.data_rdata_i, hold_q};
    rd_shift = DW'(rd_dbl >> {h_off, 3'b000});
    ext      = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (i == int'(h_sz) - 1) ext = h_sign & rd_shift[8*i+7];
    end
    load_res = '0;
    for (int i = 0; i < NB; i++) begin
      load_res[8*i +: 8] = (i < int'(h_sz)) ? rd_shift[8*i +: 8] : {8{ext}};
    end
  end

  assign lsu.rsp_valid_o = rsp_fire;
  assign lsu.rsp_we_o    = rsp_fire & h_we;
  assign lsu.rsp_err_o   = rsp_fire & (lsu.data_err_i | (~h_lo & err_hold_q));
  assign lsu.rsp_addr_o  = rsp_fire ? h_addr : 32'd0;
  assign lsu.rsp_rdata_o = (rsp_fire & ~h_we) ? load_res : '0;

  // In-order tracker of granted beats plus the split-merge hold registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      hold_q     <= '0;
      err_hold_q <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        tr_lo_q[i] <= 1'b0; tr_last_q[i] <= 1'b0; tr_we_q[i] <= 1'b0;
        tr_sign_q[i] <= 1'b0; tr_type_q[i] <= 2'b00; tr_addr_q[i] <= 32'd0;
      end
    end else begin
      if (push) begin
        tr_lo_q[wr_ptr_q]   <= (state_q == ISSUE_LO);
        tr_last_q[wr_ptr_q] <= (state_q == ISSUE_HI) | ~split_q;
        tr_we_q[wr_ptr_q]   <= we_q;
        tr_sign_q[wr_ptr_q] <= sign_q;
        tr_type_q[wr_ptr_q] <= type_q;
        tr_addr_q[wr_ptr_q] <= addr_q;
        wr_ptr_q            <= ptr_next(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_next(rd_ptr_q);
        if (!h_last) begin
          hold_q     <= lsu.data_rdata_i;
          err_hold_q <= err_hold_q | lsu.data_err_i;
        end else begin
          err_hold_q <= 1'b0;
        end
      end
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end
endmodule

// File: tb/tb_ibex_lsu_pipelined.sv
// tb/tb_ibex_lsu_pipelined.sv - randomized scoreboard bench for ibex_lsu_pipelined
module tb_ibex_lsu_pipelined;
  localparam int DW = 32;
  localparam int MO = 2;

  typedef struct { logic we; logic [1:0] typ; logic sign; logic [31:0] addr; logic [31:0] wdata; } req_t;
  typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } beat_t;
  typedef struct { logic we; logic err; logic [31:0] addr; logic [31:0] rdata; } rsp_t;
  typedef struct { logic [31:0] addr; logic we; int due; } pend_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ibex_lsu_pipelined_if #(.DW(DW)) bus ();
  ibex_lsu_pipelined #(.DW(DW), .MAX_OUTSTANDING(MO)) dut (.clk_i(clk), .rst_i(rst), .lsu(bus));

  req_t  stim_q[$];
  beat_t exp_beat_q[$];
  rsp_t  exp_rsp_q[$];
  pend_t pend_q[$];
  req_t  cur_req;
  int    total = 0, bad = 0, cyc = 0, grants = 0;
  bit    req_taken = 0, hold_rv = 0, stray = 0, prev_wait = 0;
  logic [31:0] prev_addr, prev_wdata;
  logic [3:0]  prev_be;
  logic        prev_we;

  // Memory image as a pure function of the byte address
  function automatic logic [7:0] mem_byte(logic [31:0] a);
    return 8'((a * 32'd13) ^ (a >> 7));
  endfunction

  function automatic logic [31:0] beat_data(logic [31:0] a);
    logic [31:0] d;
    for (int i = 0; i < 4; i++) d[8*i +: 8] = mem_byte(a + 32'(i));
    return d;
  endfunction

  function automatic logic berr(logic [31:0] a);
    return ((a >> 2) % 13) == 9;
  endfunction

  function automatic int sz_of(logic [1:0] t);
    return (t == 2'b00) ? 4 : (t == 2'b01) ? 2 : 1;
  endfunction

  function automatic void model_push(req_t r);
    int          sz;
    int          nbeats;
    logic [31:0] a0, ba, rel;
    logic [7:0]  top;
    beat_t       bt;
    rsp_t        e;
    sz     = sz_of(r.typ);
    a0     = {r.addr[31:2], 2'b00};
    nbeats = (int'(r.addr[1:0]) + sz > 4) ? 2 : 1;
    e.we = r.we; e.addr = r.addr; e.err = 1'b0; e.rdata = 32'd0;
    for (int b = 0; b < nbeats; b++) begin
      ba = a0 + 32'(4 * b);
      bt.addr = ba; bt.we = r.we; bt.be = 4'b0; bt.wdata = 32'd0;
      for (int i = 0; i < 4; i++) begin
        rel = ba + 32'(i) - r.addr;
        if (rel < 32'(sz)) bt.be[i] = 1'b1;
        bt.wdata[8*i +: 8] = r.wdata[8*rel[1:0] +: 8];
      end
      exp_beat_q.push_back(bt);
      if (berr(ba)) e.err = 1'b1;
    end
    if (!r.we) begin
      top = mem_byte(r.addr + 32'(sz - 1));
      for (int i = 0; i < 4; i++)
        e.rdata[8*i +: 8] = (i < sz) ? mem_byte(r.addr + 32'(i)) : ((r.sign && top[7]) ? 8'hFF : 8'h00);
    end
    exp_rsp_q.push_back(e);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Core and memory driver: inputs change 1 time unit after the rising edge
  initial begin
    pend_t p;
    bus.req_valid_i = 0; bus.req_we_i = 0; bus.req_type_i = 0; bus.req_sign_ext_i = 0;
    bus.req_addr_i = 0; bus.req_wdata_i = 0; bus.data_gnt_i = 0; bus.data_rvalid_i = 0;
    bus.data_err_i = 0; bus.data_rdata_i = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (rst) begin
        bus.req_valid_i = 0; bus.data_gnt_i = 0; bus.data_rvalid_i = 0; bus.data_err_i = 0;
        continue;
      end
      if (req_taken) begin bus.req_valid_i = 0; req_taken = 0; end
      if (!bus.req_valid_i && stim_q.size() != 0 && ($urandom % 3 != 0)) begin
        cur_req = stim_q.pop_front();
        bus.req_valid_i = 1; bus.req_we_i = cur_req.we; bus.req_type_i = cur_req.typ;
        bus.req_sign_ext_i = cur_req.sign; bus.req_addr_i = cur_req.addr; bus.req_wdata_i = cur_req.wdata;
      end
      bus.data_gnt_i = bus.data_req_o && ($urandom % 4 != 0);
      if (stray) begin
        bus.data_rvalid_i = 1; bus.data_err_i = 1; bus.data_rdata_i = $urandom;
      end else if (!hold_rv && pend_q.size() != 0 && pend_q[0].due <= cyc && ($urandom % 3 != 0)) begin
        p = pend_q.pop_front();
        bus.data_rvalid_i = 1;
        bus.data_rdata_i  = p.we ? $urandom : beat_data(p.addr);
        bus.data_err_i    = berr(p.addr);
      end else begin
        bus.data_rvalid_i = 0; bus.data_err_i = $urandom; bus.data_rdata_i = $urandom;
      end
    end
  end

  // Monitor / scoreboard on the falling edge
  initial begin
    beat_t eb;
    rsp_t  er;
    forever begin
      @(negedge clk);
      if (rst) continue;
      check("busy", 32'(bus.busy_o), 32'(exp_rsp_q.size() != 0));
      if (prev_wait) begin
        check("hold_req", 32'(bus.data_req_o), 32'd1);
        check("hold_addr", bus.data_addr_o, prev_addr);
        check("hold_be_we", {27'd0, bus.data_we_o, bus.data_be_o}, {27'd0, prev_we, prev_be});
        check("hold_wdata", bus.data_wdata_o, prev_wdata);
      end
      prev_wait = bus.data_req_o && !bus.data_gnt_i;
      prev_addr = bus.data_addr_o; prev_be = bus.data_be_o;
      prev_we = bus.data_we_o; prev_wdata = bus.data_wdata_o;
      if (bus.data_req_o && bus.data_gnt_i) begin
        check("outstanding", 32'((pend_q.size() + int'(bus.data_rvalid_i)) < MO), 32'd1);
        if (exp_beat_q.size() == 0) check("beat_unexpected", 32'd1, 32'd0);
        else begin
          eb = exp_beat_q.pop_front();
          check("beat_addr", bus.data_addr_o, eb.addr);
          check("beat_we_be", {27'd0, bus.data_we_o, bus.data_be_o}, {27'd0, eb.we, eb.be});
          if (eb.we) check("beat_wdata", bus.data_wdata_o, eb.wdata);
        end
        pend_q.push_back('{bus.data_addr_o, bus.data_we_o, cyc + int'($urandom_range(0, 4))});
        grants++;
      end
      if (bus.rsp_valid_o) begin
        if (exp_rsp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
        else begin
          er = exp_rsp_q.pop_front();
          check("rsp_we_err", {30'd0, bus.rsp_we_o, bus.rsp_err_o}, {30'd0, er.we, er.err});
          check("rsp_addr", bus.rsp_addr_o, er.addr);
          check("rsp_rdata", bus.rsp_rdata_o, er.rdata);
        end
      end
      if (bus.req_valid_i && bus.req_ready_o) begin
        model_push(cur_req);
        req_taken = 1;
      end
    end
  end

  task automatic reset_checks(string tag);
    check({tag, "_ctrl"}, {20'd0, bus.req_ready_o, bus.data_req_o, bus.data_we_o, bus.rsp_valid_o,
                           bus.rsp_we_o, bus.rsp_err_o, bus.busy_o, 1'b0, bus.data_be_o}, 32'd0);
    check({tag, "_addr"}, bus.data_addr_o | bus.rsp_addr_o, 32'd0);
    check({tag, "_data"}, bus.data_wdata_o | bus.rsp_rdata_o, 32'd0);
  endtask

  task automatic drain(int budget);
    int n;
    n = 0;
    while ((stim_q.size() != 0 || bus.req_valid_i || exp_rsp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(n >= budget), 32'd0);
  endtask

  initial begin
    req_t r;
    int   g0, n;
    repeat (2) @(negedge clk);
    reset_checks("rst_init");
    @(posedge clk); #2; rst = 0;
    @(negedge clk);
    check("idle_ready", {30'd0, bus.req_ready_o, bus.busy_o}, 32'b10);

    stim_q.push_back(req_t'{1'b0, 2'b00, 1'b0, 32'h0000_0100, 32'h0});
    stim_q.push_back(req_t'{1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0});
    stim_q.push_back(req_t'{1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0});
    stim_q.push_back(req_t'{1'b1, 2'b10, 1'b0, 32'h0000_0101, 32'h0000_00AB});
    stim_q.push_back(req_t'{1'b0, 2'b00, 1'b0, 32'h0000_00FE, 32'h0});
    stim_q.push_back(req_t'{1'b0, 2'b00, 1'b0, 32'h0000_0126, 32'h0});
    stim_q.push_back(req_t'{1'b0, 2'b00, 1'b0, 32'hFFFF_FFFE, 32'h0});
    stim_q.push_back(req_t'{1'b1, 2'b00, 1'b0, 32'h0000_0107, 32'hCAFE_F00D});
    stim_q.push_back(req_t'{1'b0, 2'b11, 1'b1, 32'h0000_010B, 32'h0});
    for (int i = 0; i < 3; i++) stim_q.push_back(req_t'{1'b0, 2'b00, 1'b0, 32'h110 + 32'(4 * i), 32'h0});
    drain(2000);

    for (int i = 0; i < 200; i++) begin
      r.we = 1'($urandom); r.typ = 2'($urandom); r.sign = 1'($urandom); r.wdata = $urandom;
      r.addr = ($urandom % 2 != 0) ? 32'h100 + 32'($urandom % 64) : 32'hFFFF_FFF8 + 32'($urandom % 8);
      stim_q.push_back(r);
    end
    drain(20000);

    // Reset with two beats in flight, then a stray rvalid
    hold_rv = 1;
    g0 = grants;
    stim_q.push_back(req_t'{1'b0, 2'b00, 1'b0, 32'h0000_0200, 32'h0});
    stim_q.push_back(req_t'{1'b0, 2'b00, 1'b0, 32'h0000_0204, 32'h0});
    n = 0;
    while (grants < g0 + 2 && n < 500) begin @(negedge clk); n++; end
    check("inflight_grants", 32'(grants - g0), 32'd2);
    @(posedge clk); #2; rst = 1;
    repeat (2) begin @(negedge clk); reset_checks("rst_mid"); end
    exp_beat_q.delete(); exp_rsp_q.delete(); pend_q.delete(); stim_q.delete();
    req_taken = 0; prev_wait = 0; hold_rv = 0;
    @(posedge clk); #2; rst = 0;
    @(negedge clk); stray = 1;
    @(negedge clk);
    check("stray_applied", 32'(bus.data_rvalid_i), 32'd1);
    check("stray_no_rsp", 32'(bus.rsp_valid_o), 32'd0);
    stray = 0;
    stim_q.push_back(req_t'{1'b0, 2'b00, 1'b0, 32'h0000_0300, 32'h0});
    drain(2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
